// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - FSM encoding and defaults shared by the SPI request arbiter
package spi_arb_pkg;

  localparam int ST_W          = 3;
  localparam int TO_CYCLES_DEF = 1023;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker: lowest index >= pointer, else wrap
module spi_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  int          pos;
  logic [IW-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest request at/after ptr wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos     = (int'(ptr_i) + i) % N_REQ;
      pos_idx = IW'(pos);
      if (req_i[pos_idx]) begin
        gnt_o          = '0;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin share of one SPI master among N requesters
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_we,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_ack,
  output logic [DW-1:0]       o_rdata,
  output logic                o_err,
  output logic [N_REQ-1:0]    o_grant,
  output logic                o_spi_read,
  output logic                o_spi_write,
  output logic [AW-1:0]       o_spi_addr,
  output logic [DW-1:0]       o_spi_wdata,
  input  logic                i_spi_done,
  input  logic [DW-1:0]       i_spi_rdata
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [AW-1:0]    addr_sel;
  logic [DW-1:0]    wdata_sel;
  logic             timeout;

  spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (idx_q == IW'(k)) begin
        addr_sel  = i_addr[k*AW +: AW];
        wdata_sel = i_wdata[k*DW +: DW];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT && !i_spi_done) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts WAIT cycles already spent; the last one expires the request.
  assign timeout = (state_q == ST_WAIT) && (cnt_q == CW'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        we_d    = i_we[idx_q];
        addr_d  = addr_sel;
        wdata_d = wdata_sel;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_spi_done) begin
          if (!we_q) begin
            rdata_d = i_spi_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        grant_d = '0;
        err_d   = 1'b0;
        ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes and ack decode straight from registered state, so reset clears them at once.
  assign o_grant     = grant_q;
  assign o_ack       = (state_q == ST_RESP) ? grant_q : '0;
  assign o_spi_read  = (state_q == ST_ISSUE) && !we_q;
  assign o_spi_write = (state_q == ST_ISSUE) && we_q;
  assign o_spi_addr  = addr_q;
  assign o_spi_wdata = wdata_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - directed table-driven bench for spi_req_arbiter
module tb_spi_req_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [3:0]  i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  o_ack;
  logic [7:0]  o_rdata;
  logic        o_err;
  logic [3:0]  o_grant;
  logic        o_spi_read;
  logic        o_spi_write;
  logic [7:0]  o_spi_addr;
  logic [7:0]  o_spi_wdata;
  logic        i_spi_done;
  logic [7:0]  i_spi_rdata;

  spi_req_arbiter #(.N_REQ(4), .AW(8), .DW(8), .TO_CYCLES(15)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_ack       (o_ack),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_grant     (o_grant),
    .o_spi_read  (o_spi_read),
    .o_spi_write (o_spi_write),
    .o_spi_addr  (o_spi_addr),
    .o_spi_wdata (o_spi_wdata),
    .i_spi_done  (i_spi_done),
    .i_spi_rdata (i_spi_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] we;
    int         lat;
    logic [7:0] mrd;
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[11];
  int   n_err = 0;
  int   n_chk = 0;
  bit   idle_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, o_grant, 0);
    chk({tag, ".ack"}, o_ack, 0);
    chk({tag, ".rd"}, o_spi_read, 0);
    chk({tag, ".wr"}, o_spi_write, 0);
    chk({tag, ".addr"}, o_spi_addr, 0);
    chk({tag, ".wdata"}, o_spi_wdata, 0);
    chk({tag, ".rdata"}, o_rdata, 0);
    chk({tag, ".err"}, o_err, 0);
  endtask

  // Called on a negedge in IDLE (idle_start) or in the RESP cycle of the previous transaction.
  task automatic run_txn(input vec_t v, input string tag);
    i_req = v.req;
    i_we  = v.we;
    if (!idle_start) begin
      @(negedge i_clk);
      chk({tag, ".idle_grant"}, o_grant, 0);
      chk({tag, ".idle_ack"}, o_ack, 0);
    end
    idle_start = 1'b0;
    @(negedge i_clk);
    chk({tag, ".grant"}, o_grant, v.gnt);
    chk({tag, ".latch_ack"}, o_ack, 0);
    @(negedge i_clk);
    chk({tag, ".read"}, o_spi_read, !v.wr);
    chk({tag, ".write"}, o_spi_write, v.wr);
    chk({tag, ".addr"}, o_spi_addr, v.addr);
    chk({tag, ".wdata"}, o_spi_wdata, v.wdata);
    @(negedge i_clk);
    chk({tag, ".strobe_1cyc"}, {o_spi_read, o_spi_write}, 0);
    for (int i = 1; i < v.lat; i++) @(negedge i_clk);
    chk({tag, ".wait_ack"}, o_ack, 0);
    i_spi_done  = 1'b1;
    i_spi_rdata = v.mrd;
    @(negedge i_clk);
    i_spi_done  = 1'b0;
    i_spi_rdata = 8'h00;
    chk({tag, ".ack"}, o_ack, v.gnt);
    chk({tag, ".rdata"}, o_rdata, v.rdata);
    chk({tag, ".err"}, o_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t post;
    int   cyc;
    int   acks;
    bit   got;

    //         req      we       lat mrd     gnt      wr    addr   wdata  rdata
    vecs[0]  = '{4'b1111, 4'b0000, 2, 8'h01, 4'b0001, 1'b0, 8'h9F, 8'h00, 8'h01};
    vecs[1]  = '{4'b1111, 4'b0000, 2, 8'h02, 4'b0010, 1'b0, 8'h11, 8'h66, 8'h02};
    vecs[2]  = '{4'b1111, 4'b0000, 2, 8'h03, 4'b0100, 1'b0, 8'h02, 8'h5A, 8'h03};
    vecs[3]  = '{4'b1111, 4'b0000, 2, 8'h04, 4'b1000, 1'b0, 8'h33, 8'h77, 8'h04};
    vecs[4]  = '{4'b1111, 4'b0000, 2, 8'h05, 4'b0001, 1'b0, 8'h9F, 8'h00, 8'h05};
    vecs[5]  = '{4'b0100, 4'b0100, 3, 8'hAA, 4'b0100, 1'b1, 8'h02, 8'h5A, 8'h05};
    vecs[6]  = '{4'b0001, 4'b0000, 5, 8'hC2, 4'b0001, 1'b0, 8'h9F, 8'h00, 8'hC2};
    vecs[7]  = '{4'b0011, 4'b0000, 1, 8'h3C, 4'b0010, 1'b0, 8'h11, 8'h66, 8'h3C};
    vecs[8]  = '{4'b1001, 4'b1000, 4, 8'h99, 4'b1000, 1'b1, 8'h33, 8'h77, 8'h3C};
    vecs[9]  = '{4'b1001, 4'b0001, 2, 8'hE1, 4'b0001, 1'b1, 8'h9F, 8'h00, 8'h3C};
    vecs[10] = '{4'b0110, 4'b0000, 1, 8'h4D, 4'b0010, 1'b0, 8'h11, 8'h66, 8'h4D};

    i_rst_n     = 1'b0;
    i_req       = '0;
    i_we        = '0;
    i_addr      = {8'h33, 8'h02, 8'h11, 8'h9F};
    i_wdata     = {8'h77, 8'h5A, 8'h66, 8'h00};
    i_spi_done  = 1'b0;
    i_spi_rdata = 8'h00;

    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n    = 1'b1;
    @(negedge i_clk);
    chk("reset.idle_grant", o_grant, 0);
    idle_start = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Owner 2 drops its request during WAIT; the transaction still completes.
    i_req = 4'b0100;
    i_we  = 4'b0000;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("drop.grant", o_grant, 4'b0100);
    @(negedge i_clk);
    chk("drop.read", o_spi_read, 1);
    @(negedge i_clk);
    i_req = 4'b0000;
    @(negedge i_clk);
    i_spi_done  = 1'b1;
    i_spi_rdata = 8'h5E;
    @(negedge i_clk);
    i_spi_done  = 1'b0;
    chk("drop.ack", o_ack, 4'b0100);
    chk("drop.rdata", o_rdata, 8'h5E);
    @(negedge i_clk);
    chk("drop.grant_clr", o_grant, 0);
    chk("drop.ack_clr", o_ack, 0);

    // A stray done while IDLE must not ack or touch read data.
    i_spi_done  = 1'b1;
    i_spi_rdata = 8'h77;
    @(negedge i_clk);
    i_spi_done  = 1'b0;
    chk("stray.ack", o_ack, 0);
    chk("stray.rdata", o_rdata, 8'h5E);
    @(negedge i_clk);
    chk("stray.ack2", o_ack, 0);
    chk("stray.grant", o_grant, 0);

    // Reset in WAIT: outputs clear at once, pointer returns to 0.
    i_req = 4'b1000;
    @(negedge i_clk);
    chk("rst.grant", o_grant, 4'b1000);
    @(negedge i_clk);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    i_req = 4'b1001;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst.held_grant", o_grant, 0);
    i_rst_n    = 1'b1;
    idle_start = 1'b1;
    post = '{4'b1001, 4'b0000, 2, 8'h6B, 4'b0001, 1'b0, 8'h9F, 8'h00, 8'h6B};
    run_txn(post, "post_rst");

    // Requester 1 read with the master never answering.
    i_req = 4'b0010;
    i_we  = 4'b0000;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("hang.grant", o_grant, 4'b0010);
    @(negedge i_clk);
    chk("hang.read", o_spi_read, 1);
`ifdef SPI_ARB_TIMEOUT_EN
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (o_ack != 0) got = 1'b1;
    end
    chk("to.latency", cyc, 16);
    chk("to.ack", o_ack, 4'b0010);
    chk("to.err", o_err, 1);
    chk("to.rdata", o_rdata, 0);
    acks = 0;
`else
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_ack != 0) acks++;
    end
    chk("hang.no_ack", acks, 0);
    chk("hang.grant_held", o_grant, 4'b0010);
    i_spi_done  = 1'b1;
    i_spi_rdata = 8'h12;
    @(negedge i_clk);
    i_spi_done  = 1'b0;
    chk("hang.ack", o_ack, 4'b0010);
    chk("hang.err", o_err, 0);
    chk("hang.rdata", o_rdata, 8'h12);
`endif
    i_req = 4'b0000;
    @(negedge i_clk);
    chk("end.grant", o_grant, 0);
    chk("end.ack", o_ack, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
